// File: rtl/median_pkg.sv
// Types and constants shared by the median window feeder and the serial median stage.
package median_pkg;

  typedef enum logic [1:0] {
    ACCEPT,
    SEND,
    WAIT
  } state_e;

  localparam int WIN_SIZE = 9;
  localparam int WIN_DIM  = 3;

endpackage

// File: rtl/median_line_buffer.sv
// Single-port line store: combinational read of the addressed entry, write on the clock edge,
// so a same-address read in the write cycle returns the old contents.
module median_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // No reset: every entry is written before a window ever reads it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 neighbourhoods from a raster pixel stream and sends each one serially to the
// median stage, stalling the input until the median stage signals completion.
//
// state  | meaning
// ACCEPT | take pixels, shift window, update line buffers
// SEND   | DSO high, stream the 9 window pixels row-major
// WAIT   | hold until MED_DONE, then pulse EOF if it was the frame's last window
module median_window_feeder
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  input  logic             MED_DONE,
  output logic             EOF
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [3:0]    IDX_END  = 4'(WIN_SIZE);

  state_e           state_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [3:0]       idx_q;
  logic [WIDTH-1:0] win_q [WIN_SIZE];
  logic [WIDTH-1:0] do_q;
  logic             dso_q;
  logic             eof_q;
  logic             last_q;

  logic               accept;
  logic [2*WIDTH-1:0] lb_rd;
  logic [2*WIDTH-1:0] lb_wd;

  assign IN_READY = (state_q == ACCEPT) && !RST;
  assign accept   = IN_VALID && IN_READY;
  assign DO       = do_q;
  assign DSO      = dso_q;
  assign EOF      = eof_q;

  // Upper half is the line two rows up, lower half the line one row up; both cascade on write.
  assign lb_wd = {lb_rd[WIDTH-1:0], IN_DATA};

  median_line_buffer #(
    .WIDTH (2 * WIDTH),
    .DEPTH (IMG_W)
  ) u_lines (
    .clk_i   (CLK),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb_wd),
    .rdata_o (lb_rd)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ACCEPT;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      do_q    <= '0;
      dso_q   <= 1'b0;
      eof_q   <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      eof_q <= 1'b0;
      case (state_q)
        ACCEPT: begin
          if (accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
              for (int c = 0; c < WIN_DIM - 1; c++) begin
                win_q[r*WIN_DIM+c] <= win_q[r*WIN_DIM+c+1];
              end
            end
            win_q[WIN_DIM-1]   <= lb_rd[2*WIDTH-1:WIDTH];
            win_q[2*WIN_DIM-1] <= lb_rd[WIDTH-1:0];
            win_q[WIN_SIZE-1]  <= IN_DATA;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
              // First beat leaves now: top-left of the shifted window is the old win_q[1].
              state_q <= SEND;
              dso_q   <= 1'b1;
              do_q    <= win_q[1];
              idx_q   <= 4'd1;
              last_q  <= (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
          end
        end
        SEND: begin
          if (idx_q == IDX_END) begin
            dso_q   <= 1'b0;
            state_q <= WAIT;
          end else begin
            do_q  <= win_q[idx_q];
            idx_q <= idx_q + 4'd1;
          end
        end
        WAIT: begin
          if (MED_DONE) begin
            state_q <= ACCEPT;
            eof_q   <= last_q;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

endmodule
